divider_scheduler: RTL and testbench

- Shares one `divider_timing` unit among four requesters.
- Arbitrates requests, latches the winner's operands and drives the divider's `Start`/`SCEN`/`Ack` handshake.
- Captures `Quotient`/`Remainder` and returns them to the granted requester over a valid/ack handshake.
- Sits between the requester blocks and a single divider instance.
- Intercepts divide-by-zero so the divider is never started with `Yin = 0`, since the divider would never terminate on it.

---
 rtl/divider_scheduler.sv | 151 +++++++++++++++
 tb/tb_divider_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_scheduler.sv
// rtl/divider_scheduler.sv - shares one divider_timing unit among four requesters
// Define DIVIDER_SCHEDULER_FIXED_PRIO_EN for fixed priority (requester 0 highest); default is round-robin.
module divider_scheduler (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [31:0] ReqX,
  input  logic [31:0] ReqY,
  output logic [3:0]  Gnt,
  output logic [3:0]  RspValid,
  input  logic [3:0]  RspAck,
  output logic [7:0]  Quotient,
  output logic [7:0]  Remainder,
  output logic        DivByZero,
  output logic        Busy,
  output logic [7:0]  DivXin,
  output logic [7:0]  DivYin,
  output logic        DivStart,
  output logic        DivSCEN,
  output logic        DivAck,
  input  logic        DivDone,
  input  logic [7:0]  DivQuotient,
  input  logic [7:0]  DivRemainder
);

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_START = 4'b0010;
  localparam logic [3:0] S_WAIT  = 4'b0100;
  localparam logic [3:0] S_RESP  = 4'b1000;

  logic [3:0] state, state_nxt;
  logic [1:0] g;
  logic [3:0] g_oh;
  logic       dz_gnt;
  logic       win_found;
  logic [1:0] win;
  logic [7:0] win_x, win_y;
  logic [1:0] arb_base;

`ifdef DIVIDER_SCHEDULER_FIXED_PRIO_EN
  assign arb_base = 2'd0;
`else
  logic [1:0] ptr;
  assign arb_base = ptr;
`endif

  // Scan from the highest offset down so the lowest offset from arb_base wins.
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = arb_base + 2'(i);
      if (Req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  assign win_x = ReqX[{win, 3'b000} +: 8];
  assign win_y = ReqY[{win, 3'b000} +: 8];
  assign g_oh  = 4'b0001 << g;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = (win_y == 8'd0) ? S_RESP : S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (DivDone) state_nxt = S_RESP;
      S_RESP:  if (RspAck[g]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Gnt      = 4'b0000;
    RspValid = 4'b0000;
    DivStart = 1'b0;
    DivSCEN  = 1'b0;
    DivAck   = 1'b0;
    Busy     = (state != S_IDLE);
    case (state)
      S_START: begin
        Gnt      = g_oh;
        DivStart = 1'b1;
      end
      S_WAIT: begin
        DivSCEN = 1'b1;
        DivAck  = DivDone;
      end
      S_RESP: begin
        RspValid = g_oh;
        Gnt      = dz_gnt ? g_oh : 4'b0000;
      end
      default: ;
    endcase
  end

  // Divide-by-zero bypasses START, so its grant is issued in the first RESP cycle instead.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      g         <= 2'd0;
      dz_gnt    <= 1'b0;
      DivXin    <= 8'h00;
      DivYin    <= 8'h00;
      Quotient  <= 8'h00;
      Remainder <= 8'h00;
      DivByZero <= 1'b0;
`ifndef DIVIDER_SCHEDULER_FIXED_PRIO_EN
      ptr       <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            g      <= win;
            DivXin <= win_x;
            DivYin <= win_y;
            if (win_y == 8'd0) begin
              Quotient  <= 8'hFF;
              Remainder <= win_x;
              DivByZero <= 1'b1;
              dz_gnt    <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (DivDone) begin
            Quotient  <= DivQuotient;
            Remainder <= DivRemainder;
            DivByZero <= 1'b0;
          end
        end
        S_RESP: begin
          dz_gnt <= 1'b0;
`ifndef DIVIDER_SCHEDULER_FIXED_PRIO_EN
          if (RspAck[g]) ptr <= g + 2'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_scheduler.sv
// tb/tb_divider_scheduler.sv - scoreboard bench for divider_scheduler with a behavioural divider
module tb_divider_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  Req;
  logic [31:0] ReqX, ReqY;
  logic [3:0]  Gnt, RspValid, RspAck;
  logic [7:0]  Quotient, Remainder;
  logic        DivByZero, Busy;
  logic [7:0]  DivXin, DivYin;
  logic        DivStart, DivSCEN, DivAck, DivDone;
  logic [7:0]  DivQuotient, DivRemainder;

  divider_scheduler dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqX(ReqX), .ReqY(ReqY),
    .Gnt(Gnt), .RspValid(RspValid), .RspAck(RspAck),
    .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero), .Busy(Busy),
    .DivXin(DivXin), .DivYin(DivYin), .DivStart(DivStart), .DivSCEN(DivSCEN),
    .DivAck(DivAck), .DivDone(DivDone), .DivQuotient(DivQuotient), .DivRemainder(DivRemainder)
  );

  always #5 Clk = ~Clk;

  // divider_timing: Done is combinational in COMPUTE once X < Y.
  logic       dv_comp;
  logic [7:0] dv_x, dv_y, dv_q;
  assign DivDone      = dv_comp && (dv_x < dv_y);
  assign DivQuotient  = dv_q;
  assign DivRemainder = dv_x;

  always @(posedge Clk) begin
    if (Reset) begin
      dv_comp <= 1'b0;
      dv_x    <= 8'h00;
      dv_y    <= 8'h00;
      dv_q    <= 8'h00;
    end else if (!dv_comp) begin
      if (DivStart) begin
        dv_comp <= 1'b1;
        dv_x    <= DivXin;
        dv_y    <= DivYin;
        dv_q    <= 8'h00;
      end
    end else if (DivDone) begin
      if (DivAck) dv_comp <= 1'b0;
    end else if (DivSCEN) begin
      dv_x <= dv_x - dv_y;
      dv_q <= dv_q + 8'd1;
    end
  end

  typedef struct packed {
    logic [3:0] who;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic rsp_t make_exp(input int idx, input logic [7:0] x, input logic [7:0] y);
    rsp_t e;
    e.who = 4'b0001 << idx;
    e.dz  = (y == 8'd0);
    e.q   = e.dz ? 8'hFF : x / y;
    e.r   = e.dz ? x : x % y;
    return e;
  endfunction

  task automatic check_rsp(input string tag);
    rsp_t e;
    check_val({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({tag, "_rspvalid"}, 32'(RspValid), 32'(e.who));
      check_val({tag, "_quotient"}, 32'(Quotient), 32'(e.q));
      check_val({tag, "_remainder"}, 32'(Remainder), 32'(e.r));
      check_val({tag, "_divbyzero"}, 32'(DivByZero), 32'(e.dz));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_gnt_rsp"}, {24'd0, Gnt, RspValid}, 32'd0);
    check_val({tag, "_ctrl"}, {27'd0, DivStart, DivSCEN, DivAck, DivByZero, Busy}, 32'd0);
    check_val({tag, "_qr"}, {16'd0, Quotient, Remainder}, 32'd0);
    check_val({tag, "_xy"}, {16'd0, DivXin, DivYin}, 32'd0);
  endtask

  task automatic run_req(input int idx, input logic [7:0] x, input logic [7:0] y, input bit bad_ack);
    rsp_t e;
    int   cyc, gnt_cnt, gnt_cyc, exp_lat;
    bit   start_seen;
    e = make_exp(idx, x, y);
    sb.push_back(e);
    exp_lat = e.dz ? 1 : 3 + int'(e.q);
    ReqX[idx*8 +: 8] = x;
    ReqY[idx*8 +: 8] = y;
    Req = e.who;
    cyc = 0; gnt_cnt = 0; gnt_cyc = 0; start_seen = 0;
    while (RspValid == 4'b0000 && cyc < 400) begin
      @(negedge Clk);
      cyc++;
      if (Gnt != 4'b0000) begin
        check_val("gnt_onehot", 32'(Gnt), 32'(e.who));
        gnt_cnt++;
        gnt_cyc = cyc;
        Req = 4'b0000;
      end
      if (DivStart) start_seen = 1;
    end
    check_val("rsp_seen", 32'(RspValid != 4'b0000), 32'd1);
    check_val("rsp_latency", 32'(cyc), 32'(exp_lat));
    check_val("gnt_count", 32'(gnt_cnt), 32'd1);
    check_val("gnt_latency", 32'(gnt_cyc), 32'd1);
    if (e.dz) check_val("dz_no_divstart", 32'(start_seen), 32'd0);
    check_rsp("req");
    if (bad_ack) begin
      RspAck = (e.who == 4'b0001) ? 4'b0010 : 4'b0001;
      repeat (2) @(negedge Clk);
      check_val("bad_ack_held", 32'(RspValid), 32'(e.who));
      check_val("bad_ack_q", 32'(Quotient), 32'(e.q));
    end
    RspAck = e.who;
    @(negedge Clk);
    RspAck = 4'b0000;
    check_val("idle_after_ack", {27'd0, RspValid, Busy}, 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req   = 4'b0000;
    RspAck = 4'b0000;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc, exp_idx;
    bit   stray;
    rsp_t e;

    ReqX = 32'd0;
    ReqY = 32'd0;
    do_reset();
    check_reset_vals("reset");

    run_req(0, 8'd100, 8'd7, 1'b0);
    run_req(2, 8'd5, 8'd9, 1'b1);
    run_req(1, 8'd33, 8'd0, 1'b0);
    run_req(3, 8'd255, 8'd1, 1'b0);
    run_req(0, 8'd0, 8'd5, 1'b0);

    // All four requesting continuously.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ReqX[k*8 +: 8] = 8'(20 + 13 * k);
      ReqY[k*8 +: 8] = 8'(k + 3);
    end
    Req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
`ifdef DIVIDER_SCHEDULER_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = n % 4;
`endif
      e = make_exp(exp_idx, ReqX[exp_idx*8 +: 8], ReqY[exp_idx*8 +: 8]);
      sb.push_back(e);
      cyc = 0;
      while (Gnt == 4'b0000 && cyc < 50) begin
        @(negedge Clk);
        cyc++;
      end
      check_val("arb_gnt", 32'(Gnt), 32'(e.who));
      cyc = 0;
      while (RspValid == 4'b0000 && cyc < 100) begin
        @(negedge Clk);
        cyc++;
      end
      check_rsp("arb");
      RspAck = RspValid;
      @(negedge Clk);
      RspAck = 4'b0000;
    end
    Req = 4'b0000;
    repeat (20) @(negedge Clk);
    check_val("arb_drain", 32'(Busy), 32'd0);
    // A trailing grant may have started before Req dropped; reset flushes it.
    do_reset();
    sb.delete();

    // Reset while the divider is computing.
    ReqX[7:0] = 8'd200;
    ReqY[7:0] = 8'd3;
    Req = 4'b0001;
    cyc = 0;
    while (Gnt == 4'b0000 && cyc < 50) begin
      @(negedge Clk);
      cyc++;
    end
    Req = 4'b0000;
    repeat (5) @(negedge Clk);
    check_val("mid_wait_scen", 32'(DivSCEN), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_reset_vals("midreset");
    stray = 0;
    repeat (10) begin
      @(negedge Clk);
      if (Gnt != 4'b0000 || RspValid != 4'b0000) stray = 1;
    end
    check_val("midreset_no_stray", 32'(stray), 32'd0);
    run_req(3, 8'd200, 8'd3, 1'b0);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
